spi_receive: RTL and testbench

SPI response receiver for the SD-card command path. It pairs with the 48-bit command sender on the same spiClock. It samples the card's MISO line, hunts for the response start bit and shifts in an R1 (8-bit) or R3/R7 (40-bit) response. For R1b commands it then waits out the card busy period. It reports completion with the same level start/finish handshake as the command sender, so the controller FSM drives both blocks identically.

---
 rtl/sd_spi_pkg.sv | 22 ++
 rtl/spi_receive_if.sv | 23 ++
 rtl/spi_receive.sv | 193 +++++++++++++++++++
 tb/tb_spi_receive.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/sd_spi_pkg.sv
// Shared types and constants for the SD-card SPI command path
// (command sender, response receiver and controller).
package sd_spi_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HUNT  = 3'd1,
        SHIFT = 3'd2,
        BUSY  = 3'd3,
        DONE  = 3'd4
    } spi_state_e;

    localparam int R1_BITS  = 8;
    localparam int R7_BITS  = 40;
    localparam int NCR_MAX  = 64;
    localparam int BUSY_MAX = 65535;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/spi_receive_if.sv
// Request/response bundle between the SD controller and the SPI response receiver.
interface spi_receive_if #(
    parameter int LONG_BITS = 40
);
    logic                 start;
    logic                 long_resp;
    logic                 wait_busy;
    logic                 bitin;
    logic [LONG_BITS-1:0] response;
    logic                 finish;
    logic                 timeout;
    logic                 running;

    modport master (
        output start, long_resp, wait_busy, bitin,
        input  response, finish, timeout, running
    );

    modport slave (
        input  start, long_resp, wait_busy, bitin,
        output response, finish, timeout, running
    );
endinterface

// File: rtl/spi_receive.sv
// SD-card SPI response receiver: hunts for the start bit on MISO, shifts in an
// R1 or R3/R7 response and optionally waits out the R1b busy period.
module spi_receive
    import sd_spi_pkg::*;
#(
    parameter int SHORT_BITS = R1_BITS,
    parameter int LONG_BITS  = R7_BITS,
    parameter int WAIT_LIMIT = NCR_MAX,
    parameter int BUSY_LIMIT = BUSY_MAX
) (
    input  logic          spi_clock,
    input  logic          reset_n,
    spi_receive_if.slave  rx
);

    localparam int CNT_W = $clog2(max_of(max_of(WAIT_LIMIT, BUSY_LIMIT), LONG_BITS) + 1);

    localparam logic [CNT_W-1:0]     CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]     CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]     SHORT_CNT = CNT_W'(SHORT_BITS);
    localparam logic [CNT_W-1:0]     LONG_CNT  = CNT_W'(LONG_BITS);
    localparam logic [CNT_W-1:0]     WAIT_CNT  = CNT_W'(WAIT_LIMIT);
    localparam logic [CNT_W-1:0]     BUSY_CNT  = CNT_W'(BUSY_LIMIT);
    localparam logic [LONG_BITS-1:0] SHORT_MASK =
        {{(LONG_BITS-SHORT_BITS){1'b0}}, {SHORT_BITS{1'b1}}};

    spi_state_e           state_r;
    spi_state_e           state_s;
    logic [CNT_W-1:0]     cnt_r;
    logic [CNT_W-1:0]     cnt_s;
    logic [CNT_W-1:0]     cnt_inc_s;
    logic [CNT_W-1:0]     target_s;
    logic [LONG_BITS-2:0] shift_r;
    logic [LONG_BITS-2:0] shift_s;
    logic [LONG_BITS-1:0] shift_word_s;
    logic [LONG_BITS-1:0] response_r;
    logic [LONG_BITS-1:0] response_s;
    logic                 long_r;
    logic                 long_s;
    logic                 wait_r;
    logic                 wait_s;
    logic                 finish_r;
    logic                 finish_s;
    logic                 timeout_r;
    logic                 timeout_s;
    logic                 running_r;
    logic                 running_s;

    // Next-state, datapath and output decode for the receive FSM.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        shift_s      = shift_r;
        response_s   = response_r;
        long_s       = long_r;
        wait_s       = wait_r;
        finish_s     = finish_r;
        timeout_s    = timeout_r;
        cnt_inc_s    = cnt_r + CNT_ONE;
        shift_word_s = {shift_r, rx.bitin};
        target_s     = long_r ? LONG_CNT : SHORT_CNT;

        case (state_r)
            IDLE: begin
                if (rx.start) begin
                    long_s    = rx.long_resp;
                    wait_s    = rx.wait_busy;
                    shift_s   = '0;
                    cnt_s     = CNT_ZERO;
                    finish_s  = 1'b0;
                    timeout_s = 1'b0;
                    state_s   = HUNT;
                end else begin
                    state_s   = IDLE;
                end
            end
            HUNT: begin
                if (!rx.start) begin
                    cnt_s     = CNT_ZERO;
                    finish_s  = 1'b0;
                    timeout_s = 1'b0;
                    state_s   = IDLE;
                end else if (!rx.bitin) begin
                    shift_s   = shift_word_s[LONG_BITS-2:0];
                    cnt_s     = CNT_ONE;
                    state_s   = SHIFT;
                end else begin
                    cnt_s = cnt_inc_s;
                    if (cnt_inc_s == WAIT_CNT) begin
                        timeout_s = 1'b1;
                        finish_s  = 1'b1;
                        state_s   = DONE;
                    end else begin
                        state_s   = HUNT;
                    end
                end
            end
            SHIFT: begin
                if (!rx.start) begin
                    cnt_s     = CNT_ZERO;
                    finish_s  = 1'b0;
                    timeout_s = 1'b0;
                    state_s   = IDLE;
                end else begin
                    shift_s = shift_word_s[LONG_BITS-2:0];
                    cnt_s   = cnt_inc_s;
                    if (cnt_inc_s == target_s) begin
                        // Short responses are masked so stale upper bits can never leak out.
                        response_s = long_r ? shift_word_s : (shift_word_s & SHORT_MASK);
                        if (wait_r) begin
                            cnt_s    = CNT_ZERO;
                            state_s  = BUSY;
                        end else begin
                            finish_s = 1'b1;
                            state_s  = DONE;
                        end
                    end else begin
                        state_s = SHIFT;
                    end
                end
            end
            BUSY: begin
                if (!rx.start) begin
                    cnt_s     = CNT_ZERO;
                    finish_s  = 1'b0;
                    timeout_s = 1'b0;
                    state_s   = IDLE;
                end else if (rx.bitin) begin
                    finish_s  = 1'b1;
                    state_s   = DONE;
                end else begin
                    cnt_s = cnt_inc_s;
                    if (cnt_inc_s == BUSY_CNT) begin
                        timeout_s = 1'b1;
                        finish_s  = 1'b1;
                        state_s   = DONE;
                    end else begin
                        state_s   = BUSY;
                    end
                end
            end
            DONE: begin
                if (!rx.start) begin
                    finish_s  = 1'b0;
                    timeout_s = 1'b0;
                    cnt_s     = CNT_ZERO;
                    state_s   = IDLE;
                end else begin
                    state_s   = DONE;
                end
            end
            default: begin
                cnt_s     = CNT_ZERO;
                finish_s  = 1'b0;
                timeout_s = 1'b0;
                state_s   = IDLE;
            end
        endcase

        running_s = (state_s == HUNT) || (state_s == SHIFT) || (state_s == BUSY);
    end

    // State, datapath and output registers with synchronous active-low reset.
    always_ff @(posedge spi_clock) begin
        if (!reset_n) begin
            state_r    <= IDLE;
            cnt_r      <= CNT_ZERO;
            shift_r    <= '0;
            response_r <= '0;
            long_r     <= 1'b0;
            wait_r     <= 1'b0;
            finish_r   <= 1'b0;
            timeout_r  <= 1'b0;
            running_r  <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            shift_r    <= shift_s;
            response_r <= response_s;
            long_r     <= long_s;
            wait_r     <= wait_s;
            finish_r   <= finish_s;
            timeout_r  <= timeout_s;
            running_r  <= running_s;
        end
    end

    assign rx.response = response_r;
    assign rx.finish   = finish_r;
    assign rx.timeout  = timeout_r;
    assign rx.running  = running_r;

endmodule

// File: tb/tb_spi_receive.sv
// Directed bench for spi_receive: a default instance plus one with a short busy limit,
// both fed the same MISO stimulus.
module tb_spi_receive;
    import sd_spi_pkg::*;

    logic clk;
    logic reset_n;
    int   n_cmp;
    int   n_err;

    spi_receive_if #(.LONG_BITS(40)) bus ();
    spi_receive_if #(.LONG_BITS(40)) bus16 ();

    assign bus16.start     = bus.start;
    assign bus16.long_resp = bus.long_resp;
    assign bus16.wait_busy = bus.wait_busy;
    assign bus16.bitin     = bus.bitin;

    spi_receive #(.SHORT_BITS(8), .LONG_BITS(40), .WAIT_LIMIT(64), .BUSY_LIMIT(65535)) dut (
        .spi_clock (clk),
        .reset_n   (reset_n),
        .rx        (bus.slave)
    );

    spi_receive #(.SHORT_BITS(8), .LONG_BITS(40), .WAIT_LIMIT(64), .BUSY_LIMIT(16)) dut16 (
        .spi_clock (clk),
        .reset_n   (reset_n),
        .rx        (bus16.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic b);
        @(negedge clk);
        bus.bitin = b;
        @(posedge clk);
        #1;
    endtask

    task automatic begin_txn(input logic lr, input logic wb);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.long_resp = lr;
        bus.wait_busy = wb;
        bus.bitin     = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic drop_start();
        @(negedge clk);
        bus.start = 1'b0;
        bus.bitin = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [39:0] v, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) begin
            step(v[i]);
        end
    endtask

    initial begin
        n_cmp         = 0;
        n_err         = 0;
        reset_n       = 1'b0;
        bus.start     = 1'b0;
        bus.long_resp = 1'b0;
        bus.wait_busy = 1'b0;
        bus.bitin     = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_finish",   {39'd0, bus.finish},  40'd0);
        check("reset_timeout",  {39'd0, bus.timeout}, 40'd0);
        check("reset_running",  {39'd0, bus.running}, 40'd0);
        check("reset_response", bus.response,         40'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // R1 0x01 after 20 idle samples
        begin_txn(1'b0, 1'b0);
        check("r1_running_hunt", {39'd0, bus.running}, 40'd1);
        repeat (20) step(1'b1);
        send_bits(40'h01, 7, 1);
        check("r1_finish_27", {39'd0, bus.finish}, 40'd0);
        send_bits(40'h01, 0, 0);
        check("r1_finish_28", {39'd0, bus.finish},  40'd1);
        check("r1_running",   {39'd0, bus.running}, 40'd0);
        check("r1_timeout",   {39'd0, bus.timeout}, 40'd0);
        check("r1_response",  bus.response,         40'h00_0000_0001);
        drop_start();
        check("r1_ack_finish", {39'd0, bus.finish}, 40'd0);

        // R7 after 3 idle samples
        begin_txn(1'b1, 1'b0);
        repeat (3) step(1'b1);
        send_bits(40'h01_0000_01AA, 39, 1);
        check("r7_finish_39", {39'd0, bus.finish}, 40'd0);
        send_bits(40'h01_0000_01AA, 0, 0);
        check("r7_finish_40", {39'd0, bus.finish}, 40'd1);
        check("r7_response",  bus.response,        40'h01_0000_01AA);
        repeat (3) step(1'b0);
        check("r7_finish_held", {39'd0, bus.finish}, 40'd1);
        drop_start();
        check("r7_ack_finish",  {39'd0, bus.finish},  40'd0);
        check("r7_ack_running", {39'd0, bus.running}, 40'd0);

        // No start bit within the hunt window
        begin_txn(1'b0, 1'b0);
        repeat (63) step(1'b1);
        check("to_finish_63", {39'd0, bus.finish}, 40'd0);
        step(1'b1);
        check("to_finish_64",  {39'd0, bus.finish},  40'd1);
        check("to_timeout_64", {39'd0, bus.timeout}, 40'd1);
        check("to_response",   bus.response,         40'h01_0000_01AA);
        drop_start();
        check("to_ack_timeout", {39'd0, bus.timeout}, 40'd0);

        // R1b: 0x00, 100 busy zeros, then ready
        begin_txn(1'b0, 1'b1);
        send_bits(40'h00, 7, 0);
        check("r1b_finish_resp", {39'd0, bus.finish},  40'd0);
        check("r1b_running",     {39'd0, bus.running}, 40'd1);
        check("r1b_response",    bus.response,         40'h00);
        repeat (16) step(1'b0);
        check("r1b16_timeout", {39'd0, bus16.timeout}, 40'd1);
        check("r1b16_finish",  {39'd0, bus16.finish},  40'd1);
        repeat (84) step(1'b0);
        check("r1b_finish_100", {39'd0, bus.finish}, 40'd0);
        step(1'b1);
        check("r1b_finish",  {39'd0, bus.finish},  40'd1);
        check("r1b_timeout", {39'd0, bus.timeout}, 40'd0);
        drop_start();

        // R1b again: short-limit instance times out at the 16th zero
        begin_txn(1'b0, 1'b1);
        send_bits(40'h00, 7, 0);
        repeat (15) step(1'b0);
        check("busy16_finish_15", {39'd0, bus16.finish}, 40'd0);
        step(1'b0);
        check("busy16_timeout", {39'd0, bus16.timeout}, 40'd1);
        check("busy16_resp",    bus16.response,         40'h00);
        repeat (4) step(1'b0);
        step(1'b1);
        check("busy_main_finish",  {39'd0, bus.finish},  40'd1);
        check("busy_main_timeout", {39'd0, bus.timeout}, 40'd0);
        drop_start();

        // Abort after 4 shift bits, then immediate restart receiving 0x05
        begin_txn(1'b0, 1'b0);
        step(1'b1);
        send_bits(40'h70, 7, 4);
        drop_start();
        check("abort_finish",   {39'd0, bus.finish},  40'd0);
        check("abort_running",  {39'd0, bus.running}, 40'd0);
        check("abort_response", bus.response,         40'h00);
        begin_txn(1'b0, 1'b0);
        send_bits(40'h05, 7, 0);
        check("restart_finish",   {39'd0, bus.finish}, 40'd1);
        check("restart_response", bus.response,        40'h05);
        drop_start();

        // Reset mid-shift, then a normal R1 of 0x7E
        begin_txn(1'b0, 1'b0);
        send_bits(40'h50, 7, 4);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check("rst_finish",   {39'd0, bus.finish},  40'd0);
        check("rst_running",  {39'd0, bus.running}, 40'd0);
        check("rst_timeout",  {39'd0, bus.timeout}, 40'd0);
        check("rst_response", bus.response,         40'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_running", {39'd0, bus.running}, 40'd1);
        send_bits(40'h7E, 7, 0);
        check("post_rst_finish",   {39'd0, bus.finish}, 40'd1);
        check("post_rst_response", bus.response,        40'h7E);
        drop_start();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
